// File: rtl/loop_counter_stack.sv
// loop_counter_stack: nestable microcode loop down-counter stack; LOOP_COUNTER_STACK_PEEK_EN adds levels_flat.
module loop_counter_stack #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [WIDTH-1:0]         count_in,
    input  logic                     load,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     next,
    output logic                     done,
    output logic [WIDTH-1:0]         count_out,
    output logic [$clog2(DEPTH)-1:0] level,
    output logic                     overflow,
    output logic                     underflow
`ifdef LOOP_COUNTER_STACK_PEEK_EN
    ,
    output logic [DEPTH*WIDTH-1:0]   levels_flat
`endif
);
    localparam int LW = $clog2(DEPTH);
    localparam logic [LW-1:0] TOP = LW'(DEPTH - 1);
    logic [WIDTH-1:0] entries [DEPTH];
    logic [LW-1:0] lvl;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
            lvl <= '0;
            overflow <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow <= push && lvl == TOP;
            underflow <= !push && pop && lvl == '0;
            if (push) begin
                if (lvl != TOP) begin
                    lvl <= lvl + LW'(1);
                    entries[lvl + LW'(1)] <= count_in;
                end
            end else if (pop) begin
                if (lvl != '0) begin
                    lvl <= lvl - LW'(1);
                    entries[lvl] <= '0;
                end
            end else if (load) begin
                entries[lvl] <= count_in;
            end else if (next && entries[lvl] != '0) begin
                entries[lvl] <= entries[lvl] - WIDTH'(1);
            end
        end
    end
    assign count_out = entries[lvl];
    assign done = count_out == '0;
    assign level = lvl;
`ifdef LOOP_COUNTER_STACK_PEEK_EN
    for (genvar i = 0; i < DEPTH; i++) begin : g_peek
        assign levels_flat[i*WIDTH +: WIDTH] = entries[i];
    end
`endif
endmodule

// File: tb/tb_loop_counter_stack.sv
// tb_loop_counter_stack: directed self-checking bench for loop_counter_stack.
module tb_loop_counter_stack;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [4:0] count_in = '0;
    logic load = 1'b0, push = 1'b0, pop = 1'b0, next = 1'b0;
    logic done, overflow, underflow;
    logic [4:0] count_out;
    logic [1:0] level;
    int tests = 0;
    int fails = 0;
`ifdef LOOP_COUNTER_STACK_PEEK_EN
    logic [19:0] levels_flat;
`endif

    loop_counter_stack #(.WIDTH(5), .DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .count_in(count_in),
        .load(load), .push(push), .pop(pop), .next(next),
        .done(done), .count_out(count_out), .level(level),
        .overflow(overflow), .underflow(underflow)
`ifdef LOOP_COUNTER_STACK_PEEK_EN
        , .levels_flat(levels_flat)
`endif
    );

    always #5 clk = ~clk;

    task automatic cmd(input logic p, input logic po, input logic l, input logic n, input logic [4:0] c);
        push = p; pop = po; load = l; next = n; count_in = c;
        @(posedge clk);
        #1;
        push = 0; pop = 0; load = 0; next = 0; count_in = '0;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic state(input string tag, input int c, input int lv, input int dn, input int ov, input int un);
        chk({tag, " count"}, int'(count_out), c);
        chk({tag, " level"}, int'(level), lv);
        chk({tag, " done"}, int'(done), dn);
        chk({tag, " overflow"}, int'(overflow), ov);
        chk({tag, " underflow"}, int'(underflow), un);
    endtask

    initial begin
        reset_n = 0;
        cmd(1, 0, 1, 1, 5'd9);
        state("reset", 0, 0, 1, 0, 0);
        reset_n = 1;
        cmd(0, 0, 1, 0, 5'd3);  state("load3", 3, 0, 0, 0, 0);
        cmd(0, 0, 0, 1, 5'd0);  state("next1", 2, 0, 0, 0, 0);
        cmd(0, 0, 0, 1, 5'd0);  state("next2", 1, 0, 0, 0, 0);
        cmd(0, 0, 0, 1, 5'd0);  state("next3", 0, 0, 1, 0, 0);
        cmd(0, 0, 0, 1, 5'd0);  state("next_sat", 0, 0, 1, 0, 0);
        cmd(0, 0, 1, 0, 5'd5);  state("load5", 5, 0, 0, 0, 0);
        cmd(0, 0, 0, 1, 5'd0);  state("nest_next", 4, 0, 0, 0, 0);
        cmd(1, 0, 0, 0, 5'd2);  state("push2", 2, 1, 0, 0, 0);
        cmd(0, 0, 0, 1, 5'd0);  state("inner1", 1, 1, 0, 0, 0);
        cmd(0, 0, 0, 1, 5'd0);  state("inner0", 0, 1, 1, 0, 0);
        cmd(0, 1, 0, 0, 5'd0);  state("pop_outer", 4, 0, 0, 0, 0);
        cmd(1, 0, 0, 0, 5'd1);  state("push_l1", 1, 1, 0, 0, 0);
        cmd(1, 0, 0, 0, 5'd2);  state("push_l2", 2, 2, 0, 0, 0);
        cmd(1, 0, 0, 0, 5'd3);  state("push_l3", 3, 3, 0, 0, 0);
        cmd(1, 0, 0, 0, 5'd4);  state("push_full", 3, 3, 0, 1, 0);
        cmd(0, 0, 0, 0, 5'd0);  state("ovf_clear", 3, 3, 0, 0, 0);
        cmd(0, 1, 0, 0, 5'd0);  state("pop_l2", 2, 2, 0, 0, 0);
        cmd(0, 1, 0, 0, 5'd0);  state("pop_l1", 1, 1, 0, 0, 0);
        cmd(0, 1, 0, 0, 5'd0);  state("pop_l0", 4, 0, 0, 0, 0);
        cmd(0, 1, 0, 0, 5'd0);  state("pop_empty", 4, 0, 0, 0, 1);
        cmd(0, 0, 0, 0, 5'd0);  state("unf_clear", 4, 0, 0, 0, 0);
        cmd(0, 0, 1, 0, 5'd31); state("load_max", 31, 0, 0, 0, 0);
        cmd(0, 0, 0, 1, 5'd0);  state("next_max", 30, 0, 0, 0, 0);
        cmd(1, 1, 1, 1, 5'd7);  state("prio_push", 7, 1, 0, 0, 0);
        cmd(0, 1, 1, 1, 5'd9);  state("prio_pop", 30, 0, 0, 0, 0);
        cmd(0, 0, 1, 1, 5'd6);  state("prio_load", 6, 0, 0, 0, 0);
        cmd(0, 0, 1, 0, 5'd0);  state("load0", 0, 0, 1, 0, 0);
        cmd(1, 0, 0, 0, 5'd8);  state("push_pre_rst", 8, 1, 0, 0, 0);
        cmd(1, 0, 0, 0, 5'd8);
        cmd(1, 0, 0, 0, 5'd8);
        cmd(1, 0, 0, 0, 5'd8);  state("full_pre_rst", 8, 3, 0, 1, 0);
        reset_n = 0;
        cmd(0, 0, 0, 0, 5'd0);  state("mid_reset", 0, 0, 1, 0, 0);
        reset_n = 1;
        cmd(0, 1, 0, 0, 5'd0);  state("pop_after_rst", 0, 0, 1, 0, 1);
`ifdef LOOP_COUNTER_STACK_PEEK_EN
        cmd(0, 0, 1, 0, 5'd9);
        cmd(1, 0, 0, 0, 5'd4);
        chk("peek", int'(levels_flat), int'({5'd0, 5'd0, 5'd4, 5'd9}));
        cmd(0, 1, 0, 0, 5'd0);
        chk("peek_pop", int'(levels_flat), 9);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
